cap_pad_emulator: RTL
=====================

# cap_pad_emulator

Synthesizable model of a capacitive touch pad. It sits on the pad side of the sensor's bidirectional pin and answers the sensor's discharge/release/measure sequence. It consumes the sensor's pad drive (`pad_out`, `pad_oe`) and returns the pad level (`pad_in`), which rises a fixed number of cycles after release. That delay is longer while `touch` is asserted. Used for on-chip loopback self-test and as the bench stimulus for the touch sensor.

## Interface
- `WIDTH`, 8: width of the charge counter and of `rise_cycles`.
- `BASE_CYCLES`, 16: charge time, in cycles, with no finger present. Must be ≥ 2.
- `TOUCH_EXTRA`, 48: additional charge cycles while touched. `BASE_CYCLES + TOUCH_EXTRA` must be ≤ 2^WIDTH − 1.

- `clk` input 1: the single clock.
- `rst_n` input 1: synchronous, active-low reset.
- `pad_out` input 1: value the sensor drives onto the pad.
- `pad_oe` input 1: sensor drive enable. 1 = driven, 0 = released (floating).
- `touch` input 1: emulated finger. 1 = touched.
- `pad_in` output 1: pad level returned to the sensor.
- `charge_done` output 1: one-cycle pulse when a charge from the discharged state completes.
- `rise_cycles` output WIDTH: threshold used by the last completed charge.
- `charge_count` output 8: number of completed charges, wraps 255 → 0.

## Operation
- Threshold: `thr = touch_q ? BASE_CYCLES+TOUCH_EXTRA : BASE_CYCLES`.
  - `touch_q` is `touch` sampled on the edge that starts a charge.
  - `thr` is frozen for the whole charge; `touch` changes mid-charge have no effect.
- State machine (`cnt` is WIDTH bits):
  - DISCHARGED:
    - `pad_oe=1,pad_out=0`: stay, `cnt=0`.
    - `pad_oe=1,pad_out=1`: go to HELD_HIGH.
    - `pad_oe=0`: go to CHARGING, `cnt=1`, latch `touch_q`.
  - CHARGING:
    - `pad_oe=1`: abort. Go to DISCHARGED (`pad_out=0`) or HELD_HIGH (`pad_out=1`). `cnt=0`. No `charge_done`, no count update.
    - Otherwise `cnt=cnt+1`.
    - If `cnt+1 == thr`: go to CHARGED, pulse `charge_done`, load `rise_cycles=thr`, increment `charge_count`.
  - CHARGED:
    - `pad_oe=0`: stay.
    - `pad_oe=1`: go to DISCHARGED or HELD_HIGH per `pad_out`.
  - HELD_HIGH:
    - `pad_oe=1,pad_out=1`: stay.
    - `pad_oe=1,pad_out=0`: go to DISCHARGED.
    - `pad_oe=0`: go to CHARGED directly. The pad is already high, so there is no `charge_done` and no count update.
- `pad_in = (state==CHARGED) || (state==HELD_HIGH)`. Decoded from registered state only; no combinational path from inputs.
- `cnt` never exceeds `thr` and never wraps.

## Timing
- Reset (edge with `rst_n=0`): state DISCHARGED, `cnt=0`, `touch_q=0`, `pad_in=0`, `charge_done=0`, `rise_cycles=0`, `charge_count=0`.
- Reset has priority over all inputs, including in the middle of a charge.
- Charge latency: edge E1 is the first edge sampling `pad_oe=0` while in DISCHARGED. `pad_in` and `charge_done` go high after edge E_thr, i.e. `thr` edges counting E1.
  - Default untouched: 16 edges.
  - Default touched: 64 edges.
- `charge_done` is high for exactly one cycle, coincident with the first cycle of `pad_in=1`. `rise_cycles` and `charge_count` update on the same edge.
- Driven transitions take effect one edge after being sampled; `pad_in` lags `pad_out` by one cycle while `pad_oe=1`.
- Re-drive in the same cycle `cnt` reaches `thr`: `pad_oe=1` wins. The charge aborts and nothing completes.
- `charge_count` at 255 plus one completed charge gives 0.

## Test plan
- Reset, then drive low (`pad_oe=1,pad_out=0`) 4 cycles, release with `touch=0`:
  - `pad_in=0` for 15 cycles, rises after the 16th edge.
  - `charge_done` pulses once.
  - `rise_cycles=16`, `charge_count=1`.
- Same sequence with `touch=1` at release → `pad_in` rises after 64 edges, `rise_cycles=64`, `charge_count=2`.
- Release with `touch=1`, deassert `touch` after 10 cycles → rise still at 64 edges.
- Release, re-drive low at cycle 30 with `touch=1` → `pad_in` stays 0, no `charge_done`, `charge_count` unchanged. A following release charges from `cnt=1` again.
- Drive high 3 cycles, then release → `pad_in=1` throughout, no `charge_done`, counts unchanged.
- Assert `rst_n=0` at cycle 8 of a charge, release reset while still floating:
  - All outputs are zero after the reset edge.
  - The next edge starts a new charge; `pad_in` rises after 16 more edges.
- Run 256 completed charges → `charge_count` wraps to 0 and `rise_cycles` holds the last threshold.

Source files
------------

// File: rtl/cap_pad_emulator.sv
// cap_pad_emulator: capacitive touch pad model answering a sensor's discharge/release/measure sequence
module cap_pad_emulator #(
    parameter int WIDTH       = 8,
    parameter int BASE_CYCLES = 16,
    parameter int TOUCH_EXTRA = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pad_out,
    input  logic             pad_oe,
    input  logic             touch,
    output logic             pad_in,
    output logic             charge_done,
    output logic [WIDTH-1:0] rise_cycles,
    output logic [7:0]       charge_count
);
    typedef enum logic [1:0] {DISCHARGED, CHARGING, CHARGED, HELD_HIGH} state_t;
    localparam logic [WIDTH-1:0] THR_BASE  = WIDTH'(BASE_CYCLES);
    localparam logic [WIDTH-1:0] THR_TOUCH = WIDTH'(BASE_CYCLES + TOUCH_EXTRA);
    state_t           state;
    state_t           driven;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] thr;
    logic             touch_q;
    assign thr    = touch_q ? THR_TOUCH : THR_BASE;
    assign driven = pad_out ? HELD_HIGH : DISCHARGED;
    assign pad_in = (state == CHARGED) || (state == HELD_HIGH);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= DISCHARGED;
            cnt          <= '0;
            touch_q      <= 1'b0;
            charge_done  <= 1'b0;
            rise_cycles  <= '0;
            charge_count <= '0;
        end else begin
            charge_done <= 1'b0;
            case (state)
                DISCHARGED: begin
                    if (pad_oe) begin
                        state <= driven;
                        cnt   <= '0;
                    end else begin
                        state   <= CHARGING;
                        cnt     <= WIDTH'(1);
                        touch_q <= touch;
                    end
                end
                CHARGING: begin
                    // a re-drive always beats completion, even on the threshold cycle
                    if (pad_oe) begin
                        state <= driven;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == thr) begin
                            state        <= CHARGED;
                            charge_done  <= 1'b1;
                            rise_cycles  <= thr;
                            charge_count <= charge_count + 1'b1;
                        end
                    end
                end
                CHARGED: begin
                    if (pad_oe) begin
                        state <= driven;
                        cnt   <= '0;
                    end
                end
                HELD_HIGH: begin
                    state <= pad_oe ? driven : CHARGED;
                    cnt   <= '0;
                end
                default: state <= DISCHARGED;
            endcase
        end
    end
endmodule
